// File: rtl/mux_pipe_skid.sv
// mux_pipe_skid: registered valid/ready pipeline stage with a one-entry skid
// buffer, placed directly after the mux2 select stage.
// IN_READY decodes only from registered state, so there is no combinational
// path from OUT_READY back to the upstream stage.
// Optional feature macro: MUX_PIPE_SKID_STALL_COUNT_EN adds a 16-bit
// saturating STALL_COUNT output.
//
// state | meaning
// EMPTY | nothing held
// BUSY  | main register valid
// FULL  | main and skid registers both valid

module mux_pipe_skid #(
   parameter int n = 32
) (
   input  logic         CLOCK,
   input  logic         RESET_N,
   input  logic [n-1:0] D,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic         FLUSH,
   output logic [n-1:0] Q,
   output logic         OUT_VALID,
   input  logic         OUT_READY
`ifdef MUX_PIPE_SKID_STALL_COUNT_EN
   ,
   output logic [15:0]  STALL_COUNT
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [n-1:0]   main_q, main_d;
   logic [n-1:0]   skid_q, skid_d;
   logic           in_fire, out_fire;

   assign OUT_VALID = (state_q != EMPTY);
   assign IN_READY  = (state_q != FULL);
   assign Q         = main_q;
   assign in_fire   = IN_VALID & IN_READY;
   assign out_fire  = OUT_VALID & OUT_READY;

   // Next-state and data-path steering; FLUSH empties the stage and drops
   // any word accepted in the same cycle, leaving the data registers as-is.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (FLUSH) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = D;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_d = D;
               end else if (in_fire) begin
                  skid_d  = D;
                  state_d = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = BUSY;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // State and data registers.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef MUX_PIPE_SKID_STALL_COUNT_EN
   logic [15:0] stall_q, stall_d;

   // Stall counter: counts edges with a word held but not taken, saturating.
   always_comb begin
      stall_d = stall_q;
      if (FLUSH) begin
         stall_d = '0;
      end else if (OUT_VALID && !OUT_READY && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // Stall counter register.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign STALL_COUNT = stall_q;
`endif

endmodule

// File: tb/tb_mux_pipe_skid.sv
// Testbench for mux_pipe_skid: directed stimulus, words pushed into a
// scoreboard queue on acceptance, and a monitor popping on every out_fire.
module tb_mux_pipe_skid;

   logic        CLOCK = 1'b0;
   logic        RESET_N;
   logic [31:0] D;
   logic        IN_VALID;
   logic        IN_READY;
   logic        FLUSH;
   logic [31:0] Q;
   logic        OUT_VALID;
   logic        OUT_READY;
`ifdef MUX_PIPE_SKID_STALL_COUNT_EN
   logic [15:0] STALL_COUNT;
`endif

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];

   always #5 CLOCK = ~CLOCK;

   mux_pipe_skid #(.n(32)) dut (
      .CLOCK    (CLOCK),
      .RESET_N  (RESET_N),
      .D        (D),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .FLUSH    (FLUSH),
      .Q        (Q),
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY)
`ifdef MUX_PIPE_SKID_STALL_COUNT_EN
      ,
      .STALL_COUNT(STALL_COUNT)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: on every out_fire the presented word must be the oldest
   // outstanding accepted word.
   always @(negedge CLOCK) begin
      if (RESET_N && !FLUSH && OUT_VALID && OUT_READY) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %h expected no word", Q);
         end else begin
            chk("q_order", Q, exp_q.pop_front());
         end
      end
   end

   // One clock edge with the given inputs; pushes the word if it is accepted.
   task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
      IN_VALID  = iv;
      D         = d;
      OUT_READY = ordy;
      FLUSH     = fl;
      @(negedge CLOCK);
      if (fl) exp_q.delete();
      else if (iv && IN_READY) exp_q.push_back(d);
      @(posedge CLOCK);
      #1;
   endtask

   initial begin
      RESET_N   = 1'b0;
      IN_VALID  = 1'b0;
      D         = '0;
      OUT_READY = 1'b0;
      FLUSH     = 1'b0;
      repeat (2) @(posedge CLOCK);
      #1;
      chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
      chk("rst_in_ready",  {31'd0, IN_READY},  32'd1);
      chk("rst_q",         Q,                  32'h0);
      RESET_N = 1'b1;

      // Streaming
      cyc(1'b1, 32'h80000000, 1'b1, 1'b0);
      chk("stream_q0",  Q, 32'h80000000);
      chk("stream_ov0", {31'd0, OUT_VALID}, 32'd1);
      cyc(1'b1, 32'h00000001, 1'b1, 1'b0);
      chk("stream_q1",  Q, 32'h00000001);
      chk("stream_ov1", {31'd0, OUT_VALID}, 32'd1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("stream_ov_end", {31'd0, OUT_VALID}, 32'd0);

      // Back-pressure
      cyc(1'b1, 32'h80000000, 1'b0, 1'b0);
      chk("bp_ir_busy", {31'd0, IN_READY}, 32'd1);
      cyc(1'b1, 32'h00000001, 1'b0, 1'b0);
      chk("bp_ir_full", {31'd0, IN_READY}, 32'd0);
      chk("bp_q_full",  Q, 32'h80000000);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_q_skid",  Q, 32'h00000001);
      chk("bp_ir_back", {31'd0, IN_READY}, 32'd1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_ov_end",  {31'd0, OUT_VALID}, 32'd0);

      // Simultaneous transfer in BUSY
      cyc(1'b1, 32'h11111111, 1'b0, 1'b0);
      cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
      chk("sim_q",  Q, 32'hDEADBEEF);
      chk("sim_ov", {31'd0, OUT_VALID}, 32'd1);
      chk("sim_ir", {31'd0, IN_READY},  32'd1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("sim_ov_end", {31'd0, OUT_VALID}, 32'd0);

      // Flush from FULL with IN_VALID high
      cyc(1'b1, 32'hAAAA0001, 1'b0, 1'b0);
      cyc(1'b1, 32'hAAAA0002, 1'b0, 1'b0);
      chk("fl_ir_full", {31'd0, IN_READY}, 32'd0);
      cyc(1'b1, 32'hAAAA0003, 1'b0, 1'b1);
      chk("fl_ov", {31'd0, OUT_VALID}, 32'd0);
      chk("fl_ir", {31'd0, IN_READY},  32'd1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fl_ov_after", {31'd0, OUT_VALID}, 32'd0);

`ifdef MUX_PIPE_SKID_STALL_COUNT_EN
      cyc(1'b1, 32'h00000005, 1'b0, 1'b0);
      chk("sc_start", {16'd0, STALL_COUNT}, 32'd0);
      repeat (5) cyc(1'b0, 32'h0, 1'b0, 1'b0);
      chk("sc_five", {16'd0, STALL_COUNT}, 32'd5);
      repeat (70000) cyc(1'b0, 32'h0, 1'b0, 1'b0);
      chk("sc_sat", {16'd0, STALL_COUNT}, 32'h0000FFFF);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      chk("sc_flush", {16'd0, STALL_COUNT}, 32'd0);
      chk("sc_flush_ov", {31'd0, OUT_VALID}, 32'd0);
`endif

      chk("sb_drained", exp_q.size(), 32'd0);

      // Asynchronous reset mid-cycle while FULL
      cyc(1'b1, 32'hBBBB0001, 1'b0, 1'b0);
      cyc(1'b1, 32'hBBBB0002, 1'b0, 1'b0);
      chk("ar_full_ir", {31'd0, IN_READY}, 32'd0);
      IN_VALID = 1'b0;
      #3;
      RESET_N = 1'b0;
      exp_q.delete();
      #1;
      chk("ar_ov", {31'd0, OUT_VALID}, 32'd0);
      chk("ar_ir", {31'd0, IN_READY},  32'd1);
      chk("ar_q",  Q, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_pipe_skid.md
# mux_pipe_skid

Registered pipeline stage with a valid/ready handshake and a one-entry skid buffer. It sits directly downstream of the `mux2` select stage. It captures the selected word `Y` on input `D` and presents it one cycle later to the next datapath stage. Back-pressure from the consumer is absorbed without a combinational ready path to the upstream stage.

## Interface
- `n`, 32, data width in bits (matches `mux2` operand width)
- `CLOCK`  input  1  single clock; all state updates on rising edge
- `RESET_N`  input  1  asynchronous, active-low reset
- `D`  input  n  data word from the upstream `mux2` output `Y`
- `IN_VALID`  input  1  upstream asserts when `D` holds a valid word
- `IN_READY`  output  1  stage can accept a word this cycle (registered)
- `FLUSH`  input  1  synchronous discard of all held words
- `Q`  output  n  held data word presented downstream
- `OUT_VALID`  output  1  `Q` holds a valid word
- `OUT_READY`  input  1  downstream accepts `Q` this cycle
- `STALL_COUNT`  output  16  saturating stall counter; present only with `MUX_PIPE_SKID_STALL_COUNT_EN`

## Operation
- Transfer definitions: in_fire = `IN_VALID` & `IN_READY`; out_fire = `OUT_VALID` & `OUT_READY`.
- Storage: main register (drives `Q`) and skid register, each n bits.
- States:
  - EMPTY: nothing held.
  - BUSY: main register valid.
  - FULL: main and skid registers both valid.
- Outputs decode from state:
  - `OUT_VALID` = (state != EMPTY).
  - `IN_READY` = (state != FULL).
  - `Q` = main register.
- Transitions:
  - EMPTY, in_fire: main <= `D`, go to BUSY.
  - BUSY, in_fire and out_fire: main <= `D`, stay BUSY.
  - BUSY, in_fire only: skid <= `D`, go to FULL.
  - BUSY, out_fire only: go to EMPTY.
  - FULL, out_fire: main <= skid, go to BUSY. No in_fire is possible because `IN_READY` = 0.
  - Any other case: hold.
- `FLUSH` = 1: next state is EMPTY regardless of in_fire or out_fire. Any word accepted in the same cycle is dropped. Data registers are not cleared.
- Ordering is strict FIFO. No word is duplicated or lost except by `FLUSH`.
- Upstream obligation: hold `D` stable while `IN_VALID` & !`IN_READY`.
- Stage guarantee: `Q` is stable while `OUT_VALID` & !`OUT_READY`.

## Timing
- Reset (`RESET_N` low, asynchronous):
  - State EMPTY.
  - `Q` = 0, skid = 0.
  - `OUT_VALID` = 0, `IN_READY` = 1, `STALL_COUNT` = 0.
- Reset release is synchronous to the next `CLOCK` edge. The first transfer can occur on the first rising edge after release.
- Latency:
  - A word accepted at edge k appears on `Q` with `OUT_VALID` = 1 after edge k.
  - A word parked in the skid register reaches `Q` one edge after the out_fire that frees the main register.
- Throughput: one word per cycle while `OUT_READY` stays high.
- `IN_READY` deasserts the cycle after the stage becomes FULL. It reasserts the cycle after a FULL-state out_fire.
- There is no combinational path from `OUT_READY` to `IN_READY`.
- Reset mid-operation: held words are lost immediately and outputs return to reset values without waiting for a clock edge.
- `FLUSH` and reset asserted together: reset dominates.

## Configuration
- `MUX_PIPE_SKID_STALL_COUNT_EN` defined:
  - Adds the `STALL_COUNT` port and a 16-bit counter.
  - The counter increments on each edge where `OUT_VALID` & !`OUT_READY`.
  - It saturates at 16'hFFFF.
  - It clears on reset or `FLUSH`.
- Not defined: no port, no counter logic; all other behaviour is identical.

## Test plan
- Reset: drive `RESET_N` = 0 mid-cycle with state FULL -> immediately `OUT_VALID` = 0, `IN_READY` = 1, `Q` = 32'h00000000.
- Streaming: `OUT_READY` = 1; present 32'h80000000 then 32'h00000001 on consecutive edges -> `Q` shows 32'h80000000 then 32'h00000001 on consecutive cycles, `OUT_VALID` continuously 1.
- Back-pressure: `OUT_READY` = 0; accept 32'h80000000 then 32'h00000001 -> `IN_READY` = 0 after the second edge. Then raise `OUT_READY` -> `Q` = 32'h80000000 for one cycle, then 32'h00000001, then `OUT_VALID` = 0. No word is lost or duplicated.
- Simultaneous transfer: in BUSY with both in_fire and out_fire, `D` = 32'hDEADBEEF -> `Q` = 32'hDEADBEEF next cycle, state remains BUSY, `IN_READY` = 1.
- Flush: in FULL with `IN_VALID` = 1, pulse `FLUSH` for one cycle -> `OUT_VALID` = 0 and `IN_READY` = 1 next cycle, and no flushed word later appears on `Q`.
- With `MUX_PIPE_SKID_STALL_COUNT_EN`: hold `OUT_VALID` = 1 with `OUT_READY` = 0 for 5 edges -> `STALL_COUNT` = 5. Then 70000 stall edges -> `STALL_COUNT` = 16'hFFFF. Then `FLUSH` -> `STALL_COUNT` = 0.
